// File: rtl/c7bexcp_if.sv
// c7bexcp_if: exception-controller bus between the _e stage, the CSR block
// and the fetch unit. The master drives the _e-stage flags and CSR values;
// the slave (c7bexcp) returns the exception/ERTN event and the fetch redirect.
interface c7bexcp_if;
  logic        valid_e;
  logic [31:0] ifu_exu_pc_e;
  logic        adef_e;
  logic        ine_e;
  logic        sys_e;
  logic        brk_e;
  logic        ale_e;
  logic        ertn_e;
  logic [31:0] mem_addr_e;
  logic        csr_ecl_crmd_ie;
  logic        csr_ecl_timer_intr;
  logic        ext_intr;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        exu_ifu_except;
  logic [5:0]  ecl_csr_exccode_e;
  logic [31:0] ecl_csr_badv_e;
  logic        ecl_csr_ertn_e;
  logic        ecl_flush;
  logic        ifu_redirect_vld;
  logic [31:0] ifu_redirect_pc;

  modport master (
    output valid_e, ifu_exu_pc_e, adef_e, ine_e, sys_e, brk_e, ale_e, ertn_e,
           mem_addr_e, csr_ecl_crmd_ie, csr_ecl_timer_intr, ext_intr,
           csr_eentry, csr_era,
    input  exu_ifu_except, ecl_csr_exccode_e, ecl_csr_badv_e, ecl_csr_ertn_e,
           ecl_flush, ifu_redirect_vld, ifu_redirect_pc
  );

  modport slave (
    input  valid_e, ifu_exu_pc_e, adef_e, ine_e, sys_e, brk_e, ale_e, ertn_e,
           mem_addr_e, csr_ecl_crmd_ie, csr_ecl_timer_intr, ext_intr,
           csr_eentry, csr_era,
    output exu_ifu_except, ecl_csr_exccode_e, ecl_csr_badv_e, ecl_csr_ertn_e,
           ecl_flush, ifu_redirect_vld, ifu_redirect_pc
  );
endinterface

// File: rtl/c7bexcp.sv
// c7bexcp: exception / interrupt request controller for the c7b core.
// Picks at most one exception or ERTN per _e instruction, reports it to the
// CSR block combinationally, redirects fetch one cycle later and then holds
// off further events for FLUSH_CYC cycles while the pipeline drains.
// Optional feature: define C7B_EXT_INTR_EN to synchronize ext_intr and let it
// raise interrupts; otherwise only the timer interrupt is taken.
module c7bexcp #(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_BIT   = 4
) (
  input logic      clk,
  input logic      resetn,
  c7bexcp_if.slave bus
);
  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [CNT_BIT-1:0] CNT_LOAD = CNT_BIT'(FLUSH_CYC - 1);

  state_t             state, state_n;
  logic [CNT_BIT-1:0] cnt, cnt_n;
  logic               ext_s;
  logic               intr_pend;
  logic               except, ertn, evt;
  logic [5:0]         code;
  logic [31:0]        badv;
  logic               redirect_vld;
  logic [31:0]        redirect_pc;

`ifdef C7B_EXT_INTR_EN
  logic [1:0] ext_sync;
  // two-flop synchronizer for the asynchronous external interrupt level
  always_ff @(posedge clk) begin
    if (!resetn) ext_sync <= 2'b00;
    else         ext_sync <= {ext_sync[0], bus.ext_intr};
  end
  assign ext_s = ext_sync[1];
`else
  // external interrupt disabled: input is consumed but never pends
  assign ext_s = 1'b0 & bus.ext_intr;
`endif

  assign intr_pend = bus.csr_ecl_crmd_ie & (bus.csr_ecl_timer_intr | ext_s);

  // priority select of the single event for the _e instruction
  always_comb begin
    except = 1'b0;
    ertn   = 1'b0;
    code   = 6'h00;
    badv   = 32'h0;
    if (resetn && state == IDLE && bus.valid_e) begin
      if (intr_pend) begin
        except = 1'b1;
      end else if (bus.adef_e) begin
        except = 1'b1;
        code   = 6'h08;
        badv   = bus.ifu_exu_pc_e;
      end else if (bus.ine_e) begin
        except = 1'b1;
        code   = 6'h0D;
      end else if (bus.sys_e) begin
        except = 1'b1;
        code   = 6'h0B;
      end else if (bus.brk_e) begin
        except = 1'b1;
        code   = 6'h0C;
      end else if (bus.ale_e) begin
        except = 1'b1;
        code   = 6'h09;
        badv   = bus.mem_addr_e;
      end else if (bus.ertn_e) begin
        ertn   = 1'b1;
      end
    end
  end

  assign evt = except | ertn;

  // drain sequencing: load counter on an event, count down, return to IDLE
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (evt) begin
        state_n = DRAIN;
        cnt_n   = CNT_LOAD;
      end
      DRAIN: if (cnt == '0) state_n = IDLE;
             else           cnt_n   = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // state, counter and registered fetch redirect
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      redirect_vld <= 1'b0;
      redirect_pc  <= 32'h0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      redirect_vld <= evt;
      if (evt) redirect_pc <= except ? bus.csr_eentry : bus.csr_era;
    end
  end

  assign bus.exu_ifu_except    = except;
  assign bus.ecl_csr_ertn_e    = ertn;
  assign bus.ecl_csr_exccode_e = code;
  assign bus.ecl_csr_badv_e    = badv;
  assign bus.ecl_flush         = resetn & (evt | (state == DRAIN));
  assign bus.ifu_redirect_vld  = redirect_vld;
  assign bus.ifu_redirect_pc   = redirect_pc;
endmodule

// File: tb/tb_c7bexcp.sv
// tb_c7bexcp: directed vector table for single events plus hand sequences
// for flush length, drain blocking, interrupt gating, reset and ext_intr.
module tb_c7bexcp;
  localparam logic [31:0] EENTRY = 32'h1C00_8000;
  localparam logic [31:0] ERA    = 32'h1C00_0200;

  logic clk = 1'b0;
  logic resetn;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  c7bexcp_if bus ();
  c7bexcp #(.FLUSH_CYC(2), .CNT_BIT(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        adef, ine, sys, brk, ale, ertn;
    logic [31:0] addr;
    logic        ie, timer;
    logic        x_exc;
    logic [5:0]  x_code;
    logic [31:0] x_badv;
    logic        x_ertn;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear();
    bus.valid_e = 0; bus.ifu_exu_pc_e = 0; bus.adef_e = 0; bus.ine_e = 0;
    bus.sys_e = 0; bus.brk_e = 0; bus.ale_e = 0; bus.ertn_e = 0;
    bus.mem_addr_e = 0; bus.csr_ecl_crmd_ie = 0; bus.csr_ecl_timer_intr = 0;
    bus.ext_intr = 0; bus.csr_eentry = EENTRY; bus.csr_era = ERA;
  endtask

  task automatic apply(input vec_t v);
    bus.valid_e = v.valid; bus.ifu_exu_pc_e = v.pc; bus.adef_e = v.adef;
    bus.ine_e = v.ine; bus.sys_e = v.sys; bus.brk_e = v.brk; bus.ale_e = v.ale;
    bus.ertn_e = v.ertn; bus.mem_addr_e = v.addr;
    bus.csr_ecl_crmd_ie = v.ie; bus.csr_ecl_timer_intr = v.timer;
  endtask

  task automatic drain();
    clear();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    //         vld pc            adf ine sys brk ale ert addr        ie tmr  exc code   badv          ertn
    vt[0]  = '{1, 32'h1C000100, 0, 0, 0, 0, 1, 0, 32'h1002,   0, 0,   1, 6'h09, 32'h1002,     0};
    vt[1]  = '{1, 32'h8,        1, 1, 0, 0, 1, 0, 32'h1002,   0, 0,   1, 6'h08, 32'h8,        0};
    vt[2]  = '{1, 32'h8,        1, 1, 0, 0, 1, 0, 32'h1002,   1, 1,   1, 6'h00, 32'h0,        0};
    vt[3]  = '{1, 32'h1C000300, 0, 0, 0, 0, 0, 1, 32'h0,      0, 0,   0, 6'h00, 32'h0,        1};
    vt[4]  = '{1, 32'h1C000300, 0, 1, 0, 0, 0, 1, 32'h0,      0, 0,   1, 6'h0D, 32'h0,        0};
    vt[5]  = '{1, 32'h1C000300, 0, 0, 0, 0, 0, 1, 32'h0,      1, 1,   1, 6'h00, 32'h0,        0};
    vt[6]  = '{1, 32'h1C000400, 0, 0, 1, 0, 0, 0, 32'h0,      0, 0,   1, 6'h0B, 32'h0,        0};
    vt[7]  = '{1, 32'h1C000400, 0, 0, 0, 1, 0, 0, 32'h0,      0, 0,   1, 6'h0C, 32'h0,        0};
    vt[8]  = '{1, 32'h1C000400, 0, 0, 0, 0, 0, 0, 32'h0,      0, 1,   0, 6'h00, 32'h0,        0};
    vt[9]  = '{0, 32'h1C000400, 0, 0, 1, 0, 1, 0, 32'h44,     1, 1,   0, 6'h00, 32'h0,        0};
    vt[10] = '{1, 32'h1C000400, 0, 0, 1, 1, 1, 0, 32'h1001,   0, 0,   1, 6'h0B, 32'h0,        0};

    // reset: outputs gated even with an excepting instruction present
    clear();
    resetn = 0;
    bus.valid_e = 1; bus.sys_e = 1;
    @(negedge clk); #1;
    chk("rst_except", 32'(bus.exu_ifu_except), 0);
    chk("rst_flush", 32'(bus.ecl_flush), 0);
    @(posedge clk); #1;
    chk("rst_redir_vld", 32'(bus.ifu_redirect_vld), 0);
    chk("rst_redir_pc", bus.ifu_redirect_pc, 0);
    clear();
    @(negedge clk); resetn = 1;

    // vector table: one instruction per entry starting from IDLE
    for (int i = 0; i < 11; i++) begin
      logic evt;
      @(negedge clk);
      apply(vt[i]);
      #1;
      evt = vt[i].x_exc | vt[i].x_ertn;
      chk($sformatf("v%0d_except", i), 32'(bus.exu_ifu_except), 32'(vt[i].x_exc));
      chk($sformatf("v%0d_code", i), 32'(bus.ecl_csr_exccode_e), 32'(vt[i].x_code));
      chk($sformatf("v%0d_badv", i), bus.ecl_csr_badv_e, vt[i].x_badv);
      chk($sformatf("v%0d_ertn", i), 32'(bus.ecl_csr_ertn_e), 32'(vt[i].x_ertn));
      chk($sformatf("v%0d_flush", i), 32'(bus.ecl_flush), 32'(evt));
      @(posedge clk); #1;
      chk($sformatf("v%0d_redir_vld", i), 32'(bus.ifu_redirect_vld), 32'(evt));
      if (evt)
        chk($sformatf("v%0d_redir_pc", i), bus.ifu_redirect_pc, vt[i].x_exc ? EENTRY : ERA);
      drain();
    end

    // flush stays high for the event cycle plus FLUSH_CYC drain cycles
    @(negedge clk);
    apply(vt[0]); #1;
    chk("ale_flush0", 32'(bus.ecl_flush), 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); clear(); #1;
      chk($sformatf("ale_flush%0d", k), 32'(bus.ecl_flush), (k < 3) ? 1 : 0);
    end
    drain();

    // back-to-back syscalls: blocked at T+1, T+2, taken again at T+3
    @(negedge clk);
    clear(); bus.valid_e = 1; bus.sys_e = 1; #1;
    chk("blk_t0", 32'(bus.exu_ifu_except), 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("blk_t%0d", k), 32'(bus.exu_ifu_except), (k == 3) ? 1 : 0);
    end
    drain();

    // interrupt gating by IE and by valid_e
    @(negedge clk);
    clear(); bus.valid_e = 1; bus.csr_ecl_timer_intr = 1; #1;
    chk("gate_ie0", 32'(bus.exu_ifu_except), 0);
    @(negedge clk);
    bus.csr_ecl_crmd_ie = 1; #1;
    chk("gate_ie1", 32'(bus.exu_ifu_except), 1);
    chk("gate_ie1_code", 32'(bus.ecl_csr_exccode_e), 0);
    drain();
    @(negedge clk);
    bus.csr_ecl_crmd_ie = 1; bus.csr_ecl_timer_intr = 1; bus.valid_e = 0; #1;
    chk("gate_novld", 32'(bus.exu_ifu_except), 0);
    chk("gate_novld_flush", 32'(bus.ecl_flush), 0);
    drain();

    // reset during DRAIN: back to IDLE, no redirect after the reset edge
    @(negedge clk);
    clear(); bus.valid_e = 1; bus.sys_e = 1; #1;
    chk("rstd_evt", 32'(bus.exu_ifu_except), 1);
    @(negedge clk);
    clear(); resetn = 0; #1;
    chk("rstd_flush", 32'(bus.ecl_flush), 0);
    @(posedge clk); #1;
    chk("rstd_redir_vld", 32'(bus.ifu_redirect_vld), 0);
    @(negedge clk);
    resetn = 1; bus.valid_e = 1; bus.sys_e = 1; #1;
    chk("rstd_idle_evt", 32'(bus.exu_ifu_except), 1);
    drain();

    // external interrupt
    @(negedge clk);
    clear(); bus.valid_e = 1; bus.csr_ecl_crmd_ie = 1; bus.ext_intr = 1; #1;
    chk("ext_c0", 32'(bus.exu_ifu_except), 0);
`ifdef C7B_EXT_INTR_EN
    @(negedge clk); #1;
    chk("ext_c1", 32'(bus.exu_ifu_except), 0);
    @(negedge clk); #1;
    chk("ext_c2", 32'(bus.exu_ifu_except), 1);
    chk("ext_c2_code", 32'(bus.ecl_csr_exccode_e), 0);
`else
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("ext_off_c%0d", k), 32'(bus.exu_ifu_except), 0);
    end
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end
endmodule
